// File: rtl/opc7_bus_pkg.sv
// Shared definitions for the OPC7 bus responder: I/O register offsets,
// control/status bit positions and the memory-cycle FSM encoding.
package opc7_bus_pkg;

  localparam logic [7:0] IO_TCOUNT  = 8'h00;
  localparam logic [7:0] IO_TRELOAD = 8'h01;
  localparam logic [7:0] IO_TCTRL   = 8'h02;
  localparam logic [7:0] IO_TSTAT   = 8'h03;
  localparam logic [7:0] IO_XSTAT   = 8'h04;
  localparam logic [7:0] IO_SCRATCH = 8'h05;

  localparam int TCTRL_EN_BIT   = 0;
  localparam int TCTRL_IE_BIT   = 1;
  localparam int TSTAT_PEND_BIT = 0;
  localparam int XSTAT_PEND_BIT = 0;

  typedef enum logic {
    ST_START = 1'b0,
    ST_WAIT  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/opc7_sram.sv
// Single-port synchronous RAM, MEM_WORDS x 32, one-cycle registered read.
// No reset on the array or read register so it maps onto block RAM.
module opc7_sram #(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Write port plus read-before-write registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/opc7_bus_responder.sv
// OPC7 bus target: wait-stated SRAM, zero-wait I/O register bank, interrupts.
// Define OPC7_BUS_TIMER_EN to build the programmable timer (registers 0x00-0x03).
module opc7_bus_responder
  import opc7_bus_pkg::*;
#(
  parameter int MEM_WORDS   = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] cpu_addr,
  input  logic [31:0] cpu_dout,
  input  logic        cpu_rnw,
  input  logic        cpu_vpa,
  input  logic        cpu_vda,
  input  logic        cpu_vio,
  output logic [31:0] cpu_din,
  output logic        cpu_clken,
  output logic [1:0]  cpu_int_b,
  input  logic        ext_irq
);

  localparam int         AW        = $clog2(MEM_WORDS);
  localparam logic [3:0] WCNT_LOAD = 4'(WAIT_STATES - 1);

  mem_state_t  state;
  logic [3:0]  wcnt;
  logic        io_cycle, mem_cycle, mem_done, mem_we, io_we;
  logic [31:0] mem_rdata, io_rdata, scratch;
  logic        xstat, ext_prev, timer_irq;
  logic        unused_addr;

  assign io_cycle    = cpu_vio;
  assign mem_cycle   = (cpu_vpa | cpu_vda) & ~cpu_vio;
  assign mem_done    = (state == ST_WAIT) && (wcnt == 4'd0);
  assign mem_we      = mem_cycle & ~cpu_rnw & mem_done & ~reset;
  assign io_we       = io_cycle & ~cpu_rnw & ~reset;
  assign cpu_clken   = reset | ~mem_cycle | mem_done;
  assign unused_addr = ^cpu_addr[19:AW];

  opc7_sram #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cpu_addr[AW-1:0]),
    .wdata (cpu_dout),
    .rdata (mem_rdata)
  );

  // Stall FSM: any cycle after a clken=1 edge restarts in START
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_START;
      wcnt  <= 4'd0;
    end else if (cpu_clken) begin
      state <= ST_START;
    end else begin
      case (state)
        ST_START: begin
          state <= ST_WAIT;
          wcnt  <= WCNT_LOAD;
        end
        ST_WAIT:  wcnt  <= wcnt - 4'd1;
        default:  state <= ST_START;
      endcase
    end
  end

`ifdef OPC7_BUS_TIMER_EN
  logic [31:0] tcount, treload;
  logic [1:0]  tctrl;
  logic        tstat, tctrl_wr, tstat_clr, timer_hit;

  assign tctrl_wr  = io_we && (cpu_addr[7:0] == IO_TCTRL);
  assign tstat_clr = io_we && (cpu_addr[7:0] == IO_TSTAT) && cpu_dout[TSTAT_PEND_BIT];
  assign timer_hit = tctrl[TCTRL_EN_BIT] && (tcount == 32'd0);
  assign timer_irq = tstat & tctrl[TCTRL_IE_BIT];

  // Free-running timer; an enable rising edge restarts from TRELOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      tcount  <= 32'd0;
      treload <= 32'd0;
      tctrl   <= 2'b00;
      tstat   <= 1'b0;
    end else begin
      if (io_we && (cpu_addr[7:0] == IO_TRELOAD)) begin
        treload <= cpu_dout;
      end
      if (tctrl_wr) begin
        tctrl <= cpu_dout[1:0];
      end
      if (tctrl_wr && cpu_dout[TCTRL_EN_BIT] && !tctrl[TCTRL_EN_BIT]) begin
        tcount <= treload;
      end else if (timer_hit) begin
        tcount <= treload;
      end else if (tctrl[TCTRL_EN_BIT]) begin
        tcount <= tcount - 32'd1;
      end
      tstat <= timer_hit | (tstat & ~tstat_clr);
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  // I/O read mux, decoded on the low address byte
  always_comb begin
    io_rdata = 32'd0;
    case (cpu_addr[7:0])
`ifdef OPC7_BUS_TIMER_EN
      IO_TCOUNT:  io_rdata = tcount;
      IO_TRELOAD: io_rdata = treload;
      IO_TCTRL:   io_rdata = {30'd0, tctrl};
      IO_TSTAT:   io_rdata = {31'd0, tstat};
`endif
      IO_XSTAT:   io_rdata = {31'd0, xstat};
      IO_SCRATCH: io_rdata = scratch;
      default:    io_rdata = 32'd0;
    endcase
  end

  // Read data is only driven for I/O reads and completing memory reads
  always_comb begin
    cpu_din = 32'd0;
    if (reset) begin
      cpu_din = 32'd0;
    end else if (io_cycle && cpu_rnw) begin
      cpu_din = io_rdata;
    end else if (mem_cycle && cpu_rnw && mem_done) begin
      cpu_din = mem_rdata;
    end else begin
      cpu_din = 32'd0;
    end
  end

  // SCRATCH, external interrupt latch (set beats clear) and interrupt outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch   <= 32'd0;
      xstat     <= 1'b0;
      ext_prev  <= 1'b0;
      cpu_int_b <= 2'b11;
    end else begin
      ext_prev <= ext_irq;
      xstat    <= (ext_irq & ~ext_prev) |
                  (xstat & ~(io_we && (cpu_addr[7:0] == IO_XSTAT) && cpu_dout[XSTAT_PEND_BIT]));
      if (io_we && (cpu_addr[7:0] == IO_SCRATCH)) begin
        scratch <= cpu_dout;
      end
      cpu_int_b <= {~xstat, ~timer_irq};
    end
  end

endmodule

// File: tb/tb_opc7_bus_responder.sv
// Self-checking bench for opc7_bus_responder: vector table, randomized traffic
// against a memory/register model, and hand sequences for interrupts and reset.
module tb_opc7_bus_responder;
  import opc7_bus_pkg::*;

  localparam int WS = 2;
  localparam int MW = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] cpu_addr;
  logic [31:0] cpu_dout;
  logic        cpu_rnw, cpu_vpa, cpu_vda, cpu_vio, ext_irq;
  logic [31:0] cpu_din;
  logic        cpu_clken;
  logic [1:0]  cpu_int_b;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  opc7_bus_responder #(.MEM_WORDS(MW), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_rnw(cpu_rnw), .cpu_vpa(cpu_vpa), .cpu_vda(cpu_vda), .cpu_vio(cpu_vio),
    .cpu_din(cpu_din), .cpu_clken(cpu_clken), .cpu_int_b(cpu_int_b), .ext_irq(ext_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.mem_we) wr_count <= wr_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        vpa, vda, vio, rnw;
    logic [19:0] addr;
    logic [31:0] data;
    logic        chk_din;
    logic [31:0] exp_din;
    int          exp_stall;
    int          exp_wr;
  } vec_t;

  function automatic vec_t v(input string name, input logic vpa, vda, vio, rnw,
                             input logic [19:0] addr, input logic [31:0] data,
                             input logic chk_din, input logic [31:0] exp_din,
                             input int exp_stall, input int exp_wr);
    vec_t r;
    r.name = name; r.vpa = vpa; r.vda = vda; r.vio = vio; r.rnw = rnw;
    r.addr = addr; r.data = data; r.chk_din = chk_din; r.exp_din = exp_din;
    r.exp_stall = exp_stall; r.exp_wr = exp_wr;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vpa, vda, vio, rnw, input logic [19:0] a, input logic [31:0] d);
    cpu_vpa = vpa; cpu_vda = vda; cpu_vio = vio; cpu_rnw = rnw; cpu_addr = a; cpu_dout = d;
  endtask

  // Holds one bus cycle until clken=1; reports stall count, completing din and SRAM writes
  task automatic txn(input logic vpa, vda, vio, rnw, input logic [19:0] a, input logic [31:0] d,
                     output logic [31:0] din, output int stalls, output int writes);
    int  w0;
    bit  done;
    done = 1'b0; stalls = 0; din = 32'd0;
    drive(vpa, vda, vio, rnw, a, d);
    w0 = wr_count;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (cpu_clken) begin
        din  = cpu_din;
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    writes = wr_count - w0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout: addr 0x%05h never completed", a);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h00000, 32'd0);
  endtask

  task automatic io_op(input logic rnw, input logic [7:0] off, input logic [31:0] d,
                       output logic [31:0] din, output logic [1:0] intb);
    drive(1'b0, 1'b0, 1'b1, rnw, {12'h000, off}, d);
    @(negedge clk);
    din  = cpu_din;
    intb = cpu_int_b;
    check("io_clken", {31'd0, cpu_clken}, 32'd1);
    @(posedge clk); #1;
  endtask

  vec_t        tbl[$];
  logic [31:0] mem_m [int];
  logic [31:0] scr_m;
  logic [31:0] din;
  logic [1:0]  intb;
  int          stalls, writes;

  initial begin
    reset = 1'b1; ext_irq = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h00000, 32'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_clken", {31'd0, cpu_clken}, 32'd1);
    check("rst_int_b", {30'd0, cpu_int_b}, 32'd3);
    check("rst_din", cpu_din, 32'd0);
    @(posedge clk); #1;
    io_op(1'b1, IO_TCTRL, 32'd0, din, intb);
    check("rst_tctrl", din, 32'd0);

    // Directed vector table
    tbl.push_back(v("wr_mem",    0, 1, 0, 0, 20'h00010, 32'hDEADBEEF, 0, 32'h0,        WS, 1));
    tbl.push_back(v("rd_mem",    0, 1, 0, 1, 20'h00010, 32'h0,        1, 32'hDEADBEEF, WS, 0));
    tbl.push_back(v("rd_alias",  1, 0, 0, 1, 20'h01010, 32'h0,        1, 32'hDEADBEEF, WS, 0));
    tbl.push_back(v("wr_scr",    0, 0, 1, 0, 20'h00005, 32'h12345678, 0, 32'h0,        0,  0));
    tbl.push_back(v("rd_scr",    0, 0, 1, 1, 20'h00005, 32'h0,        1, 32'h12345678, 0,  0));
    tbl.push_back(v("vio_prio",  0, 1, 1, 1, 20'h00005, 32'h0,        1, 32'h12345678, 0,  0));
    tbl.push_back(v("vio_wprio", 1, 0, 1, 0, 20'h00005, 32'hAAAA5555, 0, 32'h0,        0,  0));
    tbl.push_back(v("rd_scr2",   0, 0, 1, 1, 20'h00005, 32'h0,        1, 32'hAAAA5555, 0,  0));
    tbl.push_back(v("rd_unmap",  0, 0, 1, 1, 20'h00040, 32'h0,        1, 32'h0,        0,  0));
    tbl.push_back(v("wr_06",     0, 0, 1, 0, 20'h00006, 32'hFFFFFFFF, 0, 32'h0,        0,  0));
    tbl.push_back(v("rd_06",     0, 0, 1, 1, 20'h00006, 32'h0,        1, 32'h0,        0,  0));
    tbl.push_back(v("idle",      0, 0, 0, 1, 20'h00010, 32'h0,        1, 32'h0,        0,  0));
    tbl.push_back(v("wr_mem2",   1, 1, 0, 0, 20'h00011, 32'hCAFEF00D, 0, 32'h0,        WS, 1));
    tbl.push_back(v("rd_rep1",   0, 1, 0, 1, 20'h00011, 32'h0,        1, 32'hCAFEF00D, WS, 0));
    tbl.push_back(v("rd_rep2",   0, 1, 0, 1, 20'h00011, 32'h0,        1, 32'hCAFEF00D, WS, 0));
    tbl.push_back(v("rd_mem3",   1, 0, 0, 1, 20'hFF010, 32'h0,        1, 32'hDEADBEEF, WS, 0));
    foreach (tbl[i]) begin
      txn(tbl[i].vpa, tbl[i].vda, tbl[i].vio, tbl[i].rnw, tbl[i].addr, tbl[i].data, din, stalls, writes);
      check({tbl[i].name, "_stall"}, stalls, tbl[i].exp_stall);
      check({tbl[i].name, "_writes"}, writes, tbl[i].exp_wr);
      if (tbl[i].chk_din) check({tbl[i].name, "_din"}, din, tbl[i].exp_din);
    end

    // Randomized traffic against the model
    mem_m[16] = 32'hDEADBEEF;
    mem_m[17] = 32'hCAFEF00D;
    scr_m = 32'hAAAA5555;
    for (int i = 0; i < 150; i++) begin
      int          kind, idx, sel;
      logic [19:0] a;
      logic [31:0] d;
      kind = $urandom_range(0, 4);
      idx  = $urandom_range(0, 17);
      sel  = $urandom_range(1, 3);
      a    = 20'($urandom & 32'h000FF000) | 20'(idx);
      d    = $urandom;
      case (kind)
        0: begin
          txn(sel[0], sel[1], 1'b0, 1'b0, a, d, din, stalls, writes);
          mem_m[idx % MW] = d;
          check($sformatf("rnd%0d_wr_stall", i), stalls, WS);
          check($sformatf("rnd%0d_wr_writes", i), writes, 1);
        end
        1: begin
          txn(sel[0], sel[1], 1'b0, 1'b1, a, 32'd0, din, stalls, writes);
          check($sformatf("rnd%0d_rd_stall", i), stalls, WS);
          check($sformatf("rnd%0d_rd_writes", i), writes, 0);
          if (mem_m.exists(idx % MW)) check($sformatf("rnd%0d_rd_din", i), din, mem_m[idx % MW]);
        end
        2: begin
          txn(1'b0, 1'b0, 1'b1, 1'b0, 20'h00005, d, din, stalls, writes);
          scr_m = d;
          check($sformatf("rnd%0d_iow_stall", i), stalls, 0);
        end
        3: begin
          txn(1'b0, 1'b0, 1'b1, 1'b1, 20'h00005, 32'd0, din, stalls, writes);
          check($sformatf("rnd%0d_ior_stall", i), stalls, 0);
          check($sformatf("rnd%0d_ior_din", i), din, scr_m);
        end
        default: begin
          txn(1'b0, 1'b0, 1'b0, 1'b1, a, 32'd0, din, stalls, writes);
          check($sformatf("rnd%0d_idle_stall", i), stalls, 0);
          check($sformatf("rnd%0d_idle_din", i), din, 32'd0);
        end
      endcase
    end

    // External interrupt: edge detect, lagged output, no re-set while held, set beats clear
    io_op(1'b0, IO_XSTAT, 32'd1, din, intb);
    ext_irq = 1'b1;
    io_op(1'b1, IO_XSTAT, 32'd0, din, intb);
    check("x_a_din", din, 32'd0);      check("x_a_int", {31'd0, intb[1]}, 32'd1);
    io_op(1'b1, IO_XSTAT, 32'd0, din, intb);
    check("x_b_din", din, 32'd1);      check("x_b_int", {31'd0, intb[1]}, 32'd1);
    io_op(1'b1, IO_XSTAT, 32'd0, din, intb);
    check("x_c_din", din, 32'd1);      check("x_c_int", {31'd0, intb[1]}, 32'd0);
    io_op(1'b0, IO_XSTAT, 32'd1, din, intb);
    io_op(1'b1, IO_XSTAT, 32'd0, din, intb);
    check("x_held_din", din, 32'd0);   check("x_e_int", {31'd0, intb[1]}, 32'd0);
    io_op(1'b1, IO_XSTAT, 32'd0, din, intb);
    check("x_f_din", din, 32'd0);      check("x_f_int", {31'd0, intb[1]}, 32'd1);
    ext_irq = 1'b0;
    io_op(1'b1, IO_XSTAT, 32'd0, din, intb);
    ext_irq = 1'b1;
    io_op(1'b0, IO_XSTAT, 32'd1, din, intb);
    io_op(1'b1, IO_XSTAT, 32'd0, din, intb);
    check("x_setwins", din, 32'd1);
    io_op(1'b0, IO_XSTAT, 32'd1, din, intb);
    ext_irq = 1'b0;
    io_op(1'b1, IO_XSTAT, 32'd0, din, intb);
    check("x_cleared", din, 32'd0);

`ifdef OPC7_BUS_TIMER_EN
    // Timer: period TRELOAD+1, pending lagged onto int_b[0], set beats clear
    begin
      logic tstat_m, tstat_last, clr;
      int   cnt;
      io_op(1'b0, IO_TRELOAD, 32'd4, din, intb);
      io_op(1'b0, IO_TCTRL, 32'd3, din, intb);
      tstat_m = 1'b0; tstat_last = 1'b0;
      for (int k = 0; k < 20; k++) begin
        cnt = 4 - (k % 5);
        clr = (k == 12) || (k == 14);
        if (clr) begin
          io_op(1'b0, IO_TSTAT, 32'd1, din, intb);
          check($sformatf("t%0d_wdin", k), din, 32'd0);
        end else if (k == 13 || k == 15 || k == 17) begin
          io_op(1'b1, IO_TSTAT, 32'd0, din, intb);
          check($sformatf("t%0d_tstat", k), din, {31'd0, tstat_m});
        end else begin
          io_op(1'b1, IO_TCOUNT, 32'd0, din, intb);
          check($sformatf("t%0d_tcount", k), din, cnt);
        end
        check($sformatf("t%0d_int0", k), {31'd0, intb[0]}, {31'd0, ~tstat_last});
        tstat_last = tstat_m;
        tstat_m    = (cnt == 0) | (tstat_m & ~clr);
      end
      io_op(1'b0, IO_TCTRL, 32'd0, din, intb);
      io_op(1'b0, IO_TSTAT, 32'd1, din, intb);
    end
`else
    for (int r = 0; r < 4; r++) begin
      io_op(1'b0, 8'(r), 32'hFFFFFFFF, din, intb);
      io_op(1'b1, 8'(r), 32'd0, din, intb);
      check($sformatf("notimer_reg%0d", r), din, 32'd0);
      check($sformatf("notimer_int0_%0d", r), {31'd0, intb[0]}, 32'd1);
    end
`endif

    // Reset in the second stall cycle aborts the write
    txn(1'b0, 1'b1, 1'b0, 1'b0, 20'h00020, 32'h11111111, din, stalls, writes);
    check("pre_wr_writes", writes, 1);
    begin
      int w0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 20'h00020, 32'h22222222);
      w0 = wr_count;
      @(negedge clk);
      check("abort_stall1", {31'd0, cpu_clken}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h00000, 32'd0);
      @(negedge clk);
      check("abort_clken", {31'd0, cpu_clken}, 32'd1);
      check("abort_int_b", {30'd0, cpu_int_b}, 32'd3);
      @(posedge clk); #1;
      check("abort_writes", wr_count - w0, 0);
    end
    txn(1'b0, 1'b1, 1'b0, 1'b1, 20'h00020, 32'd0, din, stalls, writes);
    check("abort_rd_din", din, 32'h11111111);
    check("abort_rd_stall", stalls, WS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
